// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit with pipeline stall request.
// Optional MDU_FAST_MUL_EN: MULT/MULTU use a single registered multiplier (IDLE -> FIX).
module mul_div_unit #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CALC_CYCLES = 32 / ITER_BITS;
    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   opnd_q;
    logic [1:0]    op_q;
    logic          neg_q, rneg_q, div0_q;
    logic [31:0]   hi_q, lo_q;
    logic          done_q;

    logic          is_signed, sgn_a, sgn_b, accept;
    logic [31:0]   mag_a, mag_b, quo, rem;
    logic [63:0]   prod, fix_res;

    // One iteration: shift-add multiply on {acc_hi, multiplier}, restoring divide on {rem, dividend}.
    function automatic logic [63:0] step(input logic [63:0] acc, input logic [31:0] d,
                                         input logic is_div);
        logic [32:0] t;
        logic        qb;
        if (!is_div) begin
            t   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, d} : 33'd0);
            acc = {t, acc[31:1]};
        end else begin
            t  = {acc[63:32], acc[31]};
            qb = (t >= {1'b0, d});
            if (qb) t = t - {1'b0, d};
            acc = {t[31:0], acc[30:0], qb};
        end
        return acc;
    endfunction

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < ITER_BITS; i++) acc_d = step(acc_d, opnd_q, op_q[1]);
    end

    // 32'h8000_0000 negates to itself, which is the unsigned 2^31 magnitude.
    assign is_signed = ~op[0];
    assign sgn_a     = is_signed & src_a[31];
    assign sgn_b     = is_signed & src_b[31];
    assign mag_a     = sgn_a ? -src_a : src_a;
    assign mag_b     = sgn_b ? -src_b : src_b;
    assign accept    = (state_q == S_IDLE) && start && !flush;

    assign prod    = neg_q ? -acc_q : acc_q;
    assign quo     = div0_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
    assign rem     = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    assign fix_res = op_q[1] ? {rem, quo} : prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (accept) begin
                        op_q    <= op;
                        neg_q   <= sgn_a ^ sgn_b;
                        rneg_q  <= sgn_a;
                        div0_q  <= op[1] && (src_b == 32'd0);
                        cnt_q   <= '0;
                        opnd_q  <= op[1] ? mag_b : mag_a;
                        acc_q   <= {32'd0, op[1] ? mag_a : mag_b};
                        state_q <= S_CALC;
`ifdef MDU_FAST_MUL_EN
                        if (!op[1]) begin
                            acc_q   <= {32'd0, mag_a} * {32'd0, mag_b};
                            state_q <= S_FIX;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(CALC_CYCLES - 1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        {hi_q, lo_q} <= fix_res;
                        done_q       <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = busy | start;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int ITER_BITS   = 1;
    localparam int CALC_CYCLES = 32 / ITER_BITS;

    logic        clk, rst_n, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_err = 0;

    mul_div_unit #(.ITER_BITS(ITER_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI, LO} straight from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sx, sy;
        int     ia, ib, q, r;
        case (o)
            2'b00: begin
                sx = longint'($signed(a));
                sy = longint'($signed(b));
                return sx * sy;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                q  = ia / ib;
                r  = ia % ib;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return CALC_CYCLES + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    // Ticks until done (bounded); lat = edges taken, ndone = done pulses seen.
    task automatic wait_done(output int lat, output int ndone);
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done) begin
                ndone++;
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] e;
        int lat, nd;
        e = model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        chk({tag, ":stall_start"}, 64'(stall_req), 64'd1);
        tick();
        start = 1'b0;
        chk({tag, ":busy"}, 64'(busy), 64'd1);
        wait_done(lat, nd);
        chk({tag, ":lat"}, 64'(lat), 64'(exp_lat(o)));
        chk({tag, ":hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, ":lo"}, 64'(lo), 64'(e[31:0]));
        chk({tag, ":stall_end"}, 64'(stall_req), 64'd0);
        tick();
        chk({tag, ":done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, nd;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div_5_0", 2'b10, 32'd5, 32'd0);
        run_op("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000);

        // Flush mid-CALC keeps preloaded HI/LO and suppresses done.
        wdata = 32'd1; hi_we = 1'b1; tick(); hi_we = 1'b0;
        wdata = 32'd2; lo_we = 1'b1; tick(); lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'd1);
        chk("mtlo", 64'(lo), 64'd2);
        op = 2'b00; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'd1);
        chk("flush_lo", 64'(lo), 64'd2);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("flush_nodone", 64'(nd), 64'd0);

        // Start and flush together: not accepted.
        op = 2'b11; src_a = 32'd9; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        tick(); start = 1'b0; flush = 1'b0;
        chk("startflush_busy", 64'(busy), 64'd0);

        // Second start and MTHI while busy are both ignored.
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick(); start = 1'b0; hi_we = 1'b0;
        chk("busy_mthi_ign", 64'(hi), 64'd1);
        wait_done(lat, nd);
        chk("busy_lat", 64'(lat + 4), 64'(CALC_CYCLES + 1));
        chk("busy_hi", 64'(hi), 64'd2);
        chk("busy_lo", 64'(lo), 64'd14);
        tick();
        chk("busy_idle", 64'(busy), 64'd0);

        // MTHI in the same cycle as an accepted start lands, then the op overwrites it.
        op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd5; start = 1'b1; hi_we = 1'b1;
        wdata = 32'h0000_1234;
        tick(); start = 1'b0; hi_we = 1'b0;
        chk("mthi_start_hi", 64'(hi), 64'h1234);
        wait_done(lat, nd);
        chk("mthi_start_res", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Reset mid-CALC.
        op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        run_op("multu_max_sq", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            ro = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
